lower_mem_responder: RTL



---
 rtl/lower_mem_pkg.sv | 20 ++
 rtl/lower_mem_array.sv | 31 +++
 rtl/lower_mem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/lower_mem_pkg.sv
// rtl/lower_mem_pkg.sv - shared types and constants for the lower-memory responder
package lower_mem_pkg;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2,
        DRAIN   = 2'd3
    } resp_state_t;

    // Request fields latched on the capture edge and held for the whole transaction
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/lower_mem_array.sv
// rtl/lower_mem_array.sv - word store with two prioritised write ports and async read
module lower_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_data,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Port B is written first so a same-word port A write in the same edge lands last and wins
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_data;
        end
        if (a_we) begin
            mem[a_addr] <= a_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lower_mem_responder.sv
// rtl/lower_mem_responder.sv - fixed-latency lower-memory responder for the L1 caches
module lower_mem_responder
    import lower_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 4,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mem_request,
    input  logic [31:0]                    mem_address,
    input  logic                           mem_write_enable,
    input  logic [31:0]                    mem_write_data,
    output logic [31:0]                    mem_response_data,
    output logic                           mem_ready,
    output logic                           range_err,
    output logic                           proto_err,
    output logic [15:0]                    rd_count,
    output logic [15:0]                    wr_count,
    input  logic                           pl_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] pl_addr,
    input  logic [31:0]                    pl_data
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam int          CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(LATENCY - 1);

    resp_state_t   state;
    mem_req_t      req;
    logic [CW-1:0] cnt;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   rd_data;
    logic          commit_we;
    logic          finish_now;

    // Full-width compare keeps the whole address significant; low two bits never affect the word index
    assign in_range = ({1'b0, req.addr} < (33'(DEPTH_WORDS) << 2));
    assign idx      = req.addr[AW+1:2];

    // The WAIT edge that turns into RESPOND; a dropped request or a reset at that edge cancels it
    assign finish_now = (state == WAIT) && mem_request && (cnt == '0);
    assign commit_we  = finish_now && req.we && in_range && !rst;

    lower_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .a_we   (commit_we),
        .a_addr (idx),
        .a_data (req.wdata),
        .b_we   (pl_we),
        .b_addr (pl_addr),
        .b_data (pl_data),
        .rd_addr(idx),
        .rd_data(rd_data)
    );

    // Transaction FSM: capture, count down latency, pulse ready, then wait for the request to drop
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            req               <= '0;
            mem_ready         <= 1'b0;
            mem_response_data <= 32'd0;
            range_err         <= 1'b0;
            proto_err         <= 1'b0;
            rd_count          <= 16'd0;
            wr_count          <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_request) begin
                        req   <= '{addr: mem_address, we: mem_write_enable, wdata: mem_write_data};
                        cnt   <= LAT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_request) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_ready         <= 1'b1;
                        mem_response_data <= req.we ? 32'd0 : (in_range ? rd_data : ERR_DATA);
                        if (!in_range) begin
                            range_err <= 1'b1;
                        end
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    mem_ready <= 1'b0;
                    if (req.we) begin
                        wr_count <= wr_count + 16'd1;
                    end else begin
                        rd_count <= rd_count + 16'd1;
                    end
                    state <= mem_request ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!mem_request) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
